// File: rtl/common_lib_pkg.sv
// Common helper library shared across memory-side blocks.
// Contents:
//   clogb2(value) - number of bits needed to represent value (minimum 1).
package common_lib_pkg;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = value;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller.
// Contents:
//   SZ_* - request size encodings carried on req_size
//   state_e - controller FSM states
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between a 32-bit core port and a 32-bit memory word.
// Ports:
//   wr_size_i, wr_off_i, wr_data_i - store size, byte offset and LSB-aligned data
//   wr_be_o, wr_data_o             - byte-lane enables and lane-replicated store data
//   rd_size_i, rd_off_i            - load size and byte offset (registered by the caller)
//   rd_unsigned_i                  - zero-extend when 1, sign-extend when 0
//   rd_data_i, rd_data_o           - raw memory word in, shifted/extended load data out
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_off_i,
  input  logic        rd_unsigned_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  logic [31:0] rd_shifted;

  // Replicating data into every lane lets the enables alone pick the target bytes.
  always_comb begin
    wr_be_o   = 4'b0000;
    wr_data_o = wr_data_i;
    case (wr_size_i)
      SZ_BYTE: begin
        wr_be_o   = 4'b0001 << wr_off_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      SZ_HALF: begin
        wr_be_o   = 4'b0011 << wr_off_i;
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      SZ_WORD: begin
        wr_be_o   = 4'b1111;
        wr_data_o = wr_data_i;
      end
      default: ;
    endcase
  end

  assign rd_shifted = rd_data_i >> {rd_off_i, 3'b000};

  always_comb begin
    rd_data_o = 32'h0;
    case (rd_size_i)
      SZ_BYTE: rd_data_o = {{24{~rd_unsigned_i & rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: rd_data_o = {{16{~rd_unsigned_i & rd_shifted[15]}}, rd_shifted[15:0]};
      SZ_WORD: rd_data_o = rd_shifted;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store at a time from a core, checks it, drives a
// synchronous word-wide memory port with byte enables, and returns an extended response.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   req_valid/req_ready             - request handshake; ready only while idle
//   req_we, req_size, req_unsigned  - store flag, size (0 byte/1 half/2 word), zero-extend
//   req_addr, req_wdata             - byte address, LSB-aligned store data
//   resp_valid/resp_ready           - response handshake
//   resp_rdata, resp_err            - extended load data (0 for stores/errors), error flag
//   mem_en, mem_we, mem_addr        - memory enable, byte-lane writes, word address
//   mem_din, mem_regce, mem_dout    - lane-steered write data, output-reg enable, read data
module dmem_ctrl
  import common_lib_pkg::*;
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 8192,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEM_AW      = clogb2(MEM_DEPTH - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_regce,
  input  logic [31:0]       mem_dout
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept, issue;
  logic        misaligned, illegal, out_of_range, req_err;
  logic        last_cnt;
  logic [3:0]  lane_be;
  logic [31:0] ld_data;

  assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign illegal      = (req_size == SZ_ILL);
  assign out_of_range = ({2'b00, req_addr[31:2]} >= MEM_DEPTH);
  assign req_err      = misaligned | illegal | out_of_range;

  // Gating with rst keeps the port quiet while reset is held, not just after it releases.
  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;
  assign issue     = accept & ~req_err;

  assign mem_en    = issue;
  assign mem_we    = (issue & req_we) ? lane_be : 4'b0000;
  assign mem_addr  = req_addr[MEM_AW+1:2];
  assign mem_regce = (MEM_LATENCY == 2) && (state_q == StAccess) && !rst;

  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign last_cnt = (cnt_q == 2'(MEM_LATENCY - 1));

  dmem_lane_align u_lane_align (
    .wr_size_i     (req_size),
    .wr_off_i      (req_addr[1:0]),
    .wr_data_i     (req_wdata),
    .wr_be_o       (lane_be),
    .wr_data_o     (mem_din),
    .rd_size_i     (size_q),
    .rd_off_i      (off_q),
    .rd_unsigned_i (uns_q),
    .rd_data_i     (mem_dout),
    .rd_data_o     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          size_d  = req_size;
          off_d   = req_addr[1:0];
          uns_d   = req_unsigned;
          cnt_d   = 2'd0;
          rdata_d = 32'h0;
          err_d   = req_err;
          // Stores and rejected requests complete without waiting on read data.
          state_d = (req_err || req_we) ? StResp : StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 2'd1;
        if (last_cnt) begin
          rdata_d = ld_data;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a two-cycle memory model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en, mem_regce;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .MEM_DEPTH   (DEPTH),
    .MEM_LATENCY (LAT)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_regce    (mem_regce),
    .mem_dout     (mem_dout)
  );

  // Memory model: array read register, then output register loaded by mem_regce.
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_stage;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      if (mem_we == 4'b0000) rd_stage <= mem[mem_addr];
    end
    if (mem_regce) mem_dout <= rd_stage;
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic en, output logic [3:0] be, output logic [AW-1:0] wa,
                       output logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    en = mem_en; be = mem_we; wa = mem_addr; wd = mem_din;
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance; the response must not follow it.
    req_valid = 1'b0; req_we = ~we; req_size = 2'd3; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic e,
                           output logic en_seen);
    lat = 1;
    en_seen = 1'b0;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      en_seen = en_seen | mem_en;
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    e = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; resp_ready = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 4'b0) begin errors++; $display("FAIL rst_we: got %b expected 0000", mem_we); end
    checks++; if (mem_regce !== 1'b0) begin errors++; $display("FAIL rst_regce: got %b expected 0", mem_regce); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", resp_rdata); end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_word();
    logic en, e, ens; logic [3:0] be; logic [AW-1:0] wa; logic [31:0] wd, rd; int lat;
    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, en, be, wa, wd);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL sw_en: got %b expected 1", en); end
    checks++; if (be !== 4'b1111) begin errors++; $display("FAIL sw_we: got %b expected 1111", be); end
    checks++; if (wa !== 8'd4) begin errors++; $display("FAIL sw_addr: got %0d expected 4", wa); end
    checks++; if (wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_din: got %h expected deadbeef", wd); end
    wait_resp(lat, rd, e, ens);
    checks++; if (lat != 1) begin errors++; $display("FAIL sw_lat: got %0d expected 1", lat); end
    checks++; if ({e, rd} !== 33'h0) begin errors++; $display("FAIL sw_resp: got %b/%h expected 0/0", e, rd); end
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, en, be, wa, wd);
    checks++; if ({en, be} !== 5'b10000) begin errors++; $display("FAIL lw_en_we: got %b/%b expected 1/0000", en, be); end
    wait_resp(lat, rd, e, ens);
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL lw_lat: got %0d expected %0d", lat, LAT + 1); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", e); end
  endtask

  task automatic test_byte_half();
    logic en, e, ens; logic [3:0] be; logic [AW-1:0] wa; logic [31:0] wd, rd; int lat;
    // Word 4 becomes 0x80ADBEEF after this store.
    issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h1234_5680, en, be, wa, wd);
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL sb_we: got %b expected 1000", be); end
    checks++; if (wd !== 32'h8080_8080) begin errors++; $display("FAIL sb_din: got %h expected 80808080", wd); end
    wait_resp(lat, rd, e, ens);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h expected 00000080", rd); end
    issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'hFFFF_80AD) begin errors++; $display("FAIL lh_signed: got %h expected ffff80ad", rd); end
    issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h0000_00BE) begin errors++; $display("FAIL lbu_lane1: got %h expected 000000be", rd); end
    issue(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h0000_CAFE, en, be, wa, wd);
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_we: got %b expected 1100", be); end
    checks++; if (wd !== 32'hCAFE_CAFE) begin errors++; $display("FAIL sh_din: got %h expected cafecafe", wd); end
    checks++; if (wa !== 8'd5) begin errors++; $display("FAIL sh_addr: got %0d expected 5", wa); end
    wait_resp(lat, rd, e, ens);
    issue(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h0000_CAFE) begin errors++; $display("FAIL lhu: got %h expected 0000cafe", rd); end
    issue(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'hFFFF_CAFE) begin errors++; $display("FAIL lh_neg: got %h expected ffffcafe", rd); end
  endtask

  task automatic test_errors();
    logic en, e, ens; logic [3:0] be; logic [AW-1:0] wa; logic [31:0] wd, rd; int lat;
    logic        t_we   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  t_size [6] = '{SZ_HALF, SZ_WORD, SZ_ILL, SZ_WORD, SZ_WORD, SZ_BYTE};
    logic [31:0] t_addr [6] = '{32'h21, 32'h22, 32'h20, DEPTH * 4, 32'h12, DEPTH * 4};
    for (int i = 0; i < 6; i++) begin
      issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hFFFF_FFFF, en, be, wa, wd);
      checks++; if ({en, be} !== 5'b0) begin errors++; $display("FAIL err%0d_mem: got %b/%b expected 0/0000", i, en, be); end
      wait_resp(lat, rd, e, ens);
      checks++; if (ens !== 1'b0) begin errors++; $display("FAIL err%0d_late_en: got %b expected 0", i, ens); end
      checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_lat: got %0d expected 1", i, lat); end
      checks++; if ({e, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL err%0d_resp: got %b/%h expected 1/0", i, e, rd); end
    end
    // The rejected misaligned store must not have touched word 4.
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL err_nowrite: got %h expected 80adbeef", rd); end
    // Last in-range word is legal.
    issue(1'b0, SZ_WORD, 1'b0, DEPTH * 4 - 4, 32'h0, en, be, wa, wd);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL last_word_en: got %b expected 1", en); end
    wait_resp(lat, rd, e, ens);
    checks++; if (e !== 1'b0 || lat != LAT + 1) begin errors++; $display("FAIL last_word: got err %b lat %0d expected 0 %0d", e, lat, LAT + 1); end
  endtask

  task automatic test_back_to_back();
    logic en, e, ens; logic [3:0] be; logic [AW-1:0] wa; logic [31:0] wd, rd; int lat;
    int n;
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, en, be, wa, wd);
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != LAT + 1) begin errors++; $display("FAIL bp_lat: got %0d expected %0d", n, LAT + 1); end
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected 1", i, resp_valid); end
      checks++; if ({resp_err, resp_rdata} !== {1'b0, 32'h80AD_BEEF}) begin errors++; $display("FAIL bp_data%0d: got %b/%h expected 0/80adbeef", i, resp_err, resp_rdata); end
      checks++; if ({req_ready, mem_en} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b/%b expected 0/0", i, req_ready, mem_en); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle: got %b expected 0", req_ready); end
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({req_ready, mem_en} !== 2'b11) begin errors++; $display("FAIL bp_next_accept: got %b/%b expected 1/1", req_ready, mem_en); end
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'hFFFF_FFEF || lat != LAT + 1) begin errors++; $display("FAIL bp_second: got %h lat %0d expected ffffffef lat %0d", rd, lat, LAT + 1); end
  endtask

  task automatic test_reset_access();
    logic en, e, ens; logic [3:0] be; logic [AW-1:0] wa; logic [31:0] wd, rd; int lat;
    logic seen;
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, en, be, wa, wd);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({req_ready, resp_valid, mem_regce} !== 3'b000) begin errors++; $display("FAIL ra_during: got %b expected 000", {req_ready, resp_valid, mem_regce}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin #1 seen = seen | resp_valid; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ra_no_resp: got %b expected 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ra_idle: got %b expected 1", req_ready); end
    issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h0000_0080 || lat != LAT + 1 || e !== 1'b0) begin errors++; $display("FAIL ra_after: got %h lat %0d err %b expected 00000080 lat %0d err 0", rd, lat, e, LAT + 1); end
    // Reset in RESP after a store: the write stays, the response is dropped.
    issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, en, be, wa, wd);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rr_drop: got %b expected 0", resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, en, be, wa, wd);
    wait_resp(lat, rd, e, ens);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rr_kept: got %h expected 11223344", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
